// File: rtl/cmp_event_tracker_if.sv
// Signal bundle between a comparator-result producer and cmp_event_tracker.
// The producer drives the raw level and qualifiers; the tracker returns filtered level, events and debug state.
interface cmp_event_tracker_if #(
  parameter int CNT_W = 8
);
  // Qualifier semantics: z_in is consumed only on rising edges where
  // sample_en=1. There is no back-pressure. rise_pulse and fall_pulse are
  // each valid for exactly one cycle and are never acknowledged.
  logic             z_in;
  logic             sample_en;
  logic             clr;
  logic             z_stable;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic             count_sat;
  logic [1:0]       dbg_state;
  logic [3:0]       dbg_run;

  modport master (
    output z_in, sample_en, clr,
    input  z_stable, rise_pulse, fall_pulse, rise_count, count_sat,
    input  dbg_state, dbg_run
  );

  modport slave (
    input  z_in, sample_en, clr,
    output z_stable, rise_pulse, fall_pulse, rise_count, count_sat,
    output dbg_state, dbg_run
  );
endinterface

// File: rtl/cmp_event_tracker.sv
// Run-length glitch filter for the comparator result with rise/fall pulses and a saturating rise counter.
// Optional input synchronizer is enabled with macro CMP_EVT_SYNC_EN.
module cmp_event_tracker #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                clk,
  input logic                rst_n,
  cmp_event_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_LOW_PEND  = 2'd1,
    S_HIGH      = 2'd2,
    S_HIGH_PEND = 2'd3
  } state_e;

  localparam logic [3:0]       STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [3:0]       run_q;
  logic             z_stable_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic             z_f;
  logic [3:0]       run_inc;
  logic             commit_rise;
  logic             commit_fall;

`ifdef CMP_EVT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Free-running: the synchronizer must not stall when sampling is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.z_in;
      sync2_q <= sync1_q;
    end
  end

  assign z_f = sync2_q;
`else
  assign z_f = bus.z_in;
`endif

  always_comb begin
    run_inc     = run_q + 4'd1;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    if (bus.sample_en) begin
      unique case (state_q)
        S_LOW:       commit_rise = z_f && (STABLE_N == 4'd1);
        S_LOW_PEND:  commit_rise = z_f && (run_inc == STABLE_N);
        S_HIGH:      commit_fall = !z_f && (STABLE_N == 4'd1);
        S_HIGH_PEND: commit_fall = !z_f && (run_inc == STABLE_N);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOW;
      run_q      <= 4'd0;
      z_stable_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      rise_q <= commit_rise;
      fall_q <= commit_fall;

      if (bus.sample_en) begin
        unique case (state_q)
          S_LOW: begin
            if (z_f) begin
              if (commit_rise) begin
                state_q    <= S_HIGH;
                run_q      <= 4'd0;
                z_stable_q <= 1'b1;
              end else begin
                state_q <= S_LOW_PEND;
                run_q   <= 4'd1;
              end
            end
          end
          S_LOW_PEND: begin
            if (!z_f) begin
              state_q <= S_LOW;
              run_q   <= 4'd0;
            end else if (commit_rise) begin
              state_q    <= S_HIGH;
              run_q      <= 4'd0;
              z_stable_q <= 1'b1;
            end else begin
              run_q <= run_inc;
            end
          end
          S_HIGH: begin
            if (!z_f) begin
              if (commit_fall) begin
                state_q    <= S_LOW;
                run_q      <= 4'd0;
                z_stable_q <= 1'b0;
              end else begin
                state_q <= S_HIGH_PEND;
                run_q   <= 4'd1;
              end
            end
          end
          S_HIGH_PEND: begin
            if (z_f) begin
              state_q <= S_HIGH;
              run_q   <= 4'd0;
            end else if (commit_fall) begin
              state_q    <= S_LOW;
              run_q      <= 4'd0;
              z_stable_q <= 1'b0;
            end else begin
              run_q <= run_inc;
            end
          end
          default: begin
            state_q <= S_LOW;
            run_q   <= 4'd0;
          end
        endcase
      end

      // A clear coinciding with a rise keeps that rise: the count restarts at one.
      if (bus.clr) begin
        cnt_q <= commit_rise ? CNT_ONE : '0;
        sat_q <= 1'b0;
      end else if (commit_rise && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
        if ((cnt_q + CNT_ONE) == CNT_MAX) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  assign bus.z_stable   = z_stable_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.rise_count = cnt_q;
  assign bus.count_sat  = sat_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_run    = run_q;

endmodule

// File: doc/cmp_event_tracker.md
# cmp_event_tracker

Downstream stage for the 1-bit `comparator`: consumes its raw result `z` and removes glitches with a run-length filter. It produces a debounced `z_stable` level, single-cycle rise and fall event pulses, and a saturating count of rise events. Software and later stages observe comparator matches through this block, never through the raw `z`.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive opposite-value samples needed to commit a level change; legal range 1..15.
- `CNT_W`, default 8: width of the rise-event counter; legal range 2..16.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `z_in`  input  1  raw comparator output `z`.
- `sample_en`  input  1  sample qualifier; when 0, the block holds all state.
- `clr`  input  1  synchronous clear of `rise_count` and `count_sat`.
- `z_stable`  output  1  debounced level, registered.
- `rise_pulse`  output  1  one-cycle pulse on a committed 0→1 change.
- `fall_pulse`  output  1  one-cycle pulse on a committed 1→0 change.
- `rise_count`  output  CNT_W  number of committed rises; saturates.
- `count_sat`  output  1  sticky flag; high once `rise_count` reaches all-ones.

## Operation
- FSM states:
  - S_LOW: committed 0, no candidate.
  - S_LOW_PEND: committed 0, candidate 1 being counted.
  - S_HIGH: committed 1, no candidate.
  - S_HIGH_PEND: committed 1, candidate 0 being counted.
- Run counter `run`, width 4, counts consecutive qualified samples that differ from the committed level.
- Sample rule: FSM and `run` advance only on edges where `sample_en`=1. Otherwise they hold.
- S_LOW:
  - z=0: stay.
  - z=1: `run`←1, go to S_LOW_PEND. If STABLE_CYCLES=1, commit instead.
- S_LOW_PEND:
  - z=1: `run`←`run`+1. When the new value equals STABLE_CYCLES, commit.
  - z=0: `run`←0, return to S_LOW (candidate discarded, no pulse).
- S_HIGH and S_HIGH_PEND: symmetric, with the z polarity inverted.
- Commit 0→1: on the same edge, go to S_HIGH, `run`←0, `z_stable`←1, `rise_pulse`←1, and increment `rise_count` unless it is all-ones.
- Commit 1→0: on the same edge, go to S_LOW, `run`←0, `z_stable`←0, `fall_pulse`←1.
- Pulses are 0 on every edge without a commit. Because pulses only occur on commits, they are also 0 while `sample_en`=0.
- Saturation: when `rise_count` becomes all-ones, set `count_sat`. Further rises keep the count at all-ones; pulses are still emitted.
- `clr`:
  - Sets `rise_count`←0 and `count_sat`←0.
  - Does not affect the FSM, `run`, `z_stable` or the pulses.
  - `clr` with a same-edge rise commit: `rise_count`←1, `count_sat`←0.

## Timing
- Reset values (immediately on `rst_n` low, independent of `clk`): state S_LOW, `run`=0, `z_stable`=0, `rise_pulse`=0, `fall_pulse`=0, `rise_count`=0, `count_sat`=0.
- Reset mid-operation aborts any pending candidate. No pulse is produced for it.
- Latency with `sample_en` held at 1:
  - Let the first of STABLE_CYCLES consecutive changed samples be taken at edge k.
  - `z_stable`, the pulse and the count update at edge k+STABLE_CYCLES−1.
  - They are visible in the cycle after that edge.
- `sample_en` low between qualified samples does not break a run. Consecutiveness is counted in qualified samples only.
- Maximum committed-change rate: one per STABLE_CYCLES qualified samples. `rise_pulse` and `fall_pulse` are never high in the same cycle.

## Configuration
- `CMP_EVT_SYNC_EN` defined:
  - `z_in` passes through a 2-flop synchronizer (reset to 0) before the filter.
  - The synchronizer flops run every cycle, independent of `sample_en`.
  - All latencies increase by 2 cycles.
- `CMP_EVT_SYNC_EN` undefined: `z_in` feeds the filter directly. Use only when `z_in` is already synchronous to `clk`.

## Test plan
All scenarios use STABLE_CYCLES=4, CNT_W=4, macro undefined, `sample_en`=1 unless stated.
- Reset, then `z_in`=1 from edge 0 → `z_stable`=1 and `rise_pulse`=1 in the cycle after edge 3; `rise_count`=1; pulse low again after edge 4.
- Glitches: `z_in` high for 3 samples, low 1, high 3, low thereafter → `z_stable` stays 0, no pulses, `rise_count`=0.
- `sample_en` toggling 1,0,1,0… with `z_in`=1 → commit after the 4th qualified sample, at edge 6.
- 16 clean rise/fall cycles → `rise_count` reaches 15 with `count_sat`=1 on the 15th rise; the 16th rise still pulses, count stays 15. Then `clr` → count 0, `count_sat` 0.
- `clr` asserted on the same edge as a rise commit → `rise_count`=1, `count_sat`=0.
- `rst_n` pulsed low while in S_LOW_PEND with `run`=3 → all outputs 0 immediately; after release, 4 further high samples are needed to commit.
